// File: rtl/onebit_cell_ctrl.sv
// rtl/onebit_cell_ctrl.sv - phase sequencer for the one-bit CIM cell and sense-amp column
// Column controls are decoded from the next state and registered, so they are glitch-free at the column.
module onebit_cell_ctrl #(
  parameter int CNT_W = 4,
  parameter int T_WR  = 2,
  parameter int T_PRE = 2,
  parameter int T_SMP = 2,
  parameter int T_OVL = 1,
  parameter int T_SA  = 2,
  parameter int T_RST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [1:0] req_mode,
  input  logic       req_wdata,
  input  logic       sa_out,
  output logic       rd_valid,
  output logic       rd_data,
  output logic       err,
  output logic       busy,
  output logic       preb,
  output logic       w_en,
  output logic       write_bit,
  output logic       sampleb,
  output logic       SAE,
  output logic       WL,
  output logic       WLB
);

  localparam logic [1:0] OP_WR       = 2'b00;
  localparam logic [1:0] OP_RQ       = 2'b01;
  localparam logic [1:0] OP_RQB      = 2'b10;
  localparam logic [1:0] OP_ILL      = 2'b11;
  localparam logic [1:0] MODE_SPLIT  = 2'b00;
  localparam logic [1:0] MODE_MERGED = 2'b01;
  localparam logic [1:0] MODE_OVL    = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_PRE, S_SAMPLE, S_OVL, S_SA, S_RESET, S_ERR
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       op_q, mode_q;
  logic             done, accept, capture;
  logic             preb_n, wen_n, sampleb_n, sae_n, wl_n, wlb_n;

  // Counter reload value for a phase of length t; zero-length phases run one cycle.
  function automatic logic [CNT_W-1:0] phase_last(input int t);
    if (t <= 1) return '0;
    else return CNT_W'(t - 1);
  endfunction

  assign req_ready = (state == S_IDLE);
  assign busy      = ~req_ready;
  assign accept    = (state == S_IDLE) && req_valid;
  assign done      = (cnt == '0);
  assign capture   = done && ((state == S_SA) || (state == S_OVL && mode_q == MODE_MERGED));

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (req_valid) begin
                  if (req_op == OP_WR)       state_n = S_WRITE;
                  else if (req_op == OP_ILL) state_n = S_ERR;
                  else                       state_n = S_PRE;
                end
      S_WRITE:  if (done) state_n = S_RESET;
      S_PRE:    if (done) state_n = (mode_q == MODE_MERGED) ? S_OVL : S_SAMPLE;
      S_SAMPLE: if (done) state_n = (mode_q == MODE_OVL) ? S_OVL : S_SA;
      S_OVL:    if (done) state_n = (mode_q == MODE_MERGED) ? S_RESET : S_SA;
      S_SA:     if (done) state_n = S_RESET;
      S_RESET:  if (done) state_n = S_IDLE;
      S_ERR:    state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase

    if (state_n != state) begin
      case (state_n)
        S_WRITE:  cnt_n = phase_last(T_WR);
        S_PRE:    cnt_n = phase_last(T_PRE);
        S_SAMPLE: cnt_n = phase_last(T_SMP);
        S_OVL:    cnt_n = phase_last(T_OVL);
        S_SA:     cnt_n = phase_last(T_SA);
        S_RESET:  cnt_n = phase_last(T_RST);
        default:  cnt_n = '0;
      endcase
    end else if (!done) begin
      cnt_n = cnt - CNT_ONE;
    end else begin
      cnt_n = cnt;
    end

    preb_n    = 1'b0;
    wen_n     = 1'b0;
    sampleb_n = 1'b1;
    sae_n     = 1'b0;
    wl_n      = 1'b0;
    wlb_n     = 1'b0;
    case (state_n)
      S_WRITE:  begin preb_n = 1'b1; wen_n = 1'b1; wl_n = 1'b1; wlb_n = 1'b1; end
      S_SAMPLE: begin
                  preb_n = 1'b1; sampleb_n = 1'b0;
                  wl_n = (op_q == OP_RQ); wlb_n = (op_q == OP_RQB);
                end
      S_OVL:    begin
                  preb_n = 1'b1; sampleb_n = 1'b0; sae_n = 1'b1;
                  wl_n = (op_q == OP_RQ); wlb_n = (op_q == OP_RQB);
                end
      S_SA:     begin preb_n = 1'b1; sae_n = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= OP_WR;
      mode_q    <= MODE_SPLIT;
      preb      <= 1'b0;
      w_en      <= 1'b0;
      write_bit <= 1'b0;
      sampleb   <= 1'b1;
      SAE       <= 1'b0;
      WL        <= 1'b0;
      WLB       <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      preb     <= preb_n;
      w_en     <= wen_n;
      sampleb  <= sampleb_n;
      SAE      <= sae_n;
      WL       <= wl_n;
      WLB      <= wlb_n;
      rd_valid <= capture;
      err      <= accept && (req_op == OP_ILL);
      if (accept) begin
        op_q   <= req_op;
        mode_q <= (req_mode == 2'b11) ? MODE_SPLIT : req_mode;
        if (req_op == OP_WR) write_bit <= req_wdata;
      end
      // QB reads sense the complement node, so the stored bit is the inverse.
      if (capture) rd_data <= sa_out ^ (op_q == OP_RQB);
    end
  end

endmodule
